imm_extend_q: RTL and testbench
===============================

# imm_extend_q

Parametrised, buffered successor to the single-cycle RV32I immediate extender. It sits between decode and execute: it accepts one instruction word plus immediate-format select per handshake, produces an XLEN-wide extended immediate, and queues results in a small FIFO with valid/ready flow control. It adds formats the RV32I unit lacks (CSR zimm, shift amount), flags illegal selects, and keeps a saturating illegal-event counter.

## Interface
- XLEN, 32: immediate/output width; legal values 32, 64.
- DEPTH, 2: FIFO entries; power of two, 2..8.
- TAG_W, 5: width of the sideband tag carried with each entry (e.g. ROB/PC index).
- CNT_W, 8: width of the illegal-event counter.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all queued entries.
- in_valid  in  1  input entry present.
- in_ready  out  1  input can be accepted; equals (count != DEPTH).
- instr  in  32  instruction word.
- immsrc  in  3  format select.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer takes head entry.
- out_imm  out  XLEN  extended immediate of head entry.
- out_illegal  out  1  head entry had an illegal select.
- out_tag  out  TAG_W  tag of head entry.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal entries.

## Operation
- Push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
- Immediate computed combinationally from instr/immsrc at push; stored result, not raw instr. sext() replicates instr[31] to XLEN.
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 100 U: sext({instr[31:12], 12'b0}) (upper bits sign-filled when XLEN=64).
  - 101 Z: zero-extend instr[19:15].
  - 110 SH: XLEN=64: zero-extend instr[25:20]; XLEN=32: zero-extend instr[24:20], illegal if instr[25]=1.
  - 111: illegal; imm 0.
- Illegal entries are still queued (imm 0, out_illegal 1); downstream decides the trap.
- FIFO: read/write pointers wrap modulo DEPTH; count 0..DEPTH; strict in-order delivery.
- When out_valid=0, out_imm, out_illegal, out_tag drive 0.
- illegal_cnt increments by 1 per pushed illegal entry; holds at 2^CNT_W-1; cleared only by reset (not flush).
- flush: next cycle count=0, out_valid=0; any push/pop in the flush cycle is discarded; illegal_cnt does not count an entry discarded by flush.

## Timing
- Reset (asynchronous assert, synchronous deassert): count=0, pointers=0, out_valid=0, out_imm=0, out_illegal=0, out_tag=0, illegal_cnt=0; in_ready=1.
- Latency: entry pushed at edge N appears on out_* after edge N (one cycle), when the FIFO was empty.
- Throughput: one entry per cycle while not full.
- in_ready depends only on registered count; no combinational path from out_ready to in_ready.
- Full: in_ready=0 even if out_ready=1 that cycle; a push is possible the cycle after the pop.
- Empty: pop ignored; simultaneous push+pop with count in 1..DEPTH-1 leaves count unchanged.
- Reset asserted mid-transfer: all entries lost immediately; no partial entry is ever presented.

## Test plan
- XLEN=32, instr=0xFFF00093, immsrc=000 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0; instr=0xFE000EE3, immsrc=010 -> out_imm=0xFFFFFFFC.
- XLEN=64, instr=0x800000B7, immsrc=100 -> out_imm=0xFFFFFFFF80000000; instr=0x02001093, immsrc=110 -> out_imm=0x20, illegal 0.
- XLEN=32, instr=0x02001093, immsrc=110 -> out_illegal=1, out_imm=0, illegal_cnt 0->1; 300 illegal pushes with CNT_W=8 -> illegal_cnt=255.
- DEPTH=2, out_ready=0, push tags 1,2,3 -> in_ready=0 after two pushes, tag 3 held; set out_ready=1 -> tags out 1,2,3 in order, no loss or duplication.
- Full FIFO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entry never appears, illegal_cnt unchanged.
- Assert reset with 2 entries queued -> out_valid=0 and all outputs 0 immediately; after release, first push emerges after one cycle.

Source files
------------

// File: rtl/imm_extend_q.sv
// Buffered immediate extender between decode and execute. Each accepted
// instruction word is decoded into an XLEN-wide immediate at push time and
// the result (not the raw word) is queued in a small in-order FIFO with
// valid/ready flow control. Illegal selects are queued with imm 0 and a flag,
// and counted by a saturating counter that only reset clears.
module imm_extend_q #(
  parameter int XLEN  = 32,  // 32 or 64
  parameter int DEPTH = 2,   // power of two, 2..8
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_B   = 3'b010,
    FMT_J   = 3'b011,
    FMT_U   = 3'b100,
    FMT_Z   = 3'b101,
    FMT_SH  = 3'b110,
    FMT_BAD = 3'b111
  } fmt_e;

  // Sign-extend a 32-bit value to XLEN; written without zero-width
  // replication so it holds for XLEN=32 as well as 64.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [XLEN-1:0]  imm_val;
  logic             imm_illegal;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic [XLEN-1:0]  imm_mem [DEPTH];
  logic             ill_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic push, pop;

  // Decode the immediate for the presented instruction word.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a value held and infer a latch.
    imm_val     = '0;
    imm_illegal = 1'b0;
    unique case (fmt_e'(immsrc))
      FMT_I: imm_val = sext32({{20{instr[31]}}, instr[31:20]});
      FMT_S: imm_val = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
      FMT_B: imm_val = sext32({{19{instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0});
      FMT_J: imm_val = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0});
      FMT_U: imm_val = sext32({instr[31:12], 12'b0});
      FMT_Z: imm_val = {{(XLEN-5){1'b0}}, instr[19:15]};
      FMT_SH: begin
        if (XLEN == 64) begin
          imm_val = {{(XLEN-6){1'b0}}, instr[25:20]};
        end else if (instr[25]) begin
          imm_illegal = 1'b1;  // shamt >= 32 has no meaning on RV32
        end else begin
          imm_val = {{(XLEN-5){1'b0}}, instr[24:20]};
        end
      end
      FMT_BAD: imm_illegal = 1'b1;
    endcase
  end

  // Handshake qualification; flush discards any transfer in its cycle.
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // Next-state for pointers, occupancy and the illegal-event counter.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);  // power-of-two wrap
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push && imm_illegal && (illegal_cnt_q != '1)) begin
        illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Entry storage, written on push.
  // NOTE: storage carries no reset; an entry is only visible while count
  // covers it, and the outputs are gated to 0 when the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem[wr_ptr_q] <= imm_val;
      ill_mem[wr_ptr_q] <= imm_illegal;
      tag_mem[wr_ptr_q] <= in_tag;
    end
  end

  // Head-of-queue outputs, forced to zero while empty.
  always_comb begin
    out_imm     = out_valid ? imm_mem[rd_ptr_q] : '0;
    out_illegal = out_valid ? ill_mem[rd_ptr_q] : 1'b0;
    out_tag     = out_valid ? tag_mem[rd_ptr_q] : '0;
    illegal_cnt = illegal_cnt_q;
  end

endmodule

// File: tb/tb_imm_extend_q.sv
// Self-checking bench for imm_extend_q. An XLEN=32 and an XLEN=64 instance
// see the same input stream; a queue-based model predicts both and is
// compared every cycle, alongside directed literal expectations.
module tb_imm_extend_q;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  immsrc = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32;
  logic [4:0]  out_tag32;
  logic [7:0]  cnt32;

  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag64;
  logic [7:0]  cnt64;

  imm_extend_q #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(5), .CNT_W(8)) u32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_illegal(out_ill32), .out_tag(out_tag32),
    .illegal_cnt(cnt32)
  );

  imm_extend_q #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(5), .CNT_W(8)) u64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_illegal(out_ill64), .out_tag(out_tag64),
    .illegal_cnt(cnt64)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference immediate: treat the word as a signed integer and use
  // arithmetic shifts / field placement to build each format's value.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins,
                                          input logic [2:0] src,
                                          input bit is64, output bit ill);
    longint s, v;
    s   = longint'($signed(ins));
    v   = 0;
    ill = 1'b0;
    case (src)
      3'd0: v = s >>> 20;
      3'd1: v = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2: v = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
              | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd3: v = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
              | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      3'd4: v = (s >>> 12) <<< 12;
      3'd5: v = longint'(ins[19:15]);
      3'd6: begin
        if (is64)         v = longint'(ins[25:20]);
        else if (ins[25]) ill = 1'b1;
        else              v = longint'(ins[24:20]);
      end
      default: ill = 1'b1;
    endcase
    return is64 ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
  endfunction

  typedef struct {
    logic [63:0] imm32;
    logic [63:0] imm64;
    bit          ill32;
    bit          ill64;
    logic [4:0]  tag;
  } ent_t;

  ent_t mq[$];
  int   cnt32_m = 0;
  int   cnt64_m = 0;

  // Model: transfers decided from the inputs seen at each rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      cnt32_m = 0;
      cnt64_m = 0;
    end else begin
      bit do_push, do_pop;
      ent_t e;
      do_push = in_valid && (mq.size() != DEPTH) && !flush;
      do_pop  = (mq.size() != 0) && out_ready && !flush;
      if (flush) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          e.imm32 = ref_imm(instr, immsrc, 1'b0, e.ill32);
          e.imm64 = ref_imm(instr, immsrc, 1'b1, e.ill64);
          e.tag   = in_tag;
          mq.push_back(e);
          if (e.ill32 && cnt32_m < 255) cnt32_m++;
          if (e.ill64 && cnt64_m < 255) cnt64_m++;
        end
      end
    end
  end

  // Compare both instances against the model every falling edge.
  always @(negedge clk) begin
    bit v;
    logic [63:0] e32, e64;
    bit i32, i64;
    logic [4:0] et;
    v = (mq.size() != 0);
    e32 = '0; e64 = '0; i32 = 1'b0; i64 = 1'b0; et = '0;
    if (v) begin
      e32 = mq[0].imm32; e64 = mq[0].imm64;
      i32 = mq[0].ill32; i64 = mq[0].ill64; et = mq[0].tag;
    end
    check("m32 out_valid", out_valid32, v);
    check("m32 in_ready", in_ready32, mq.size() != DEPTH);
    check("m32 out_imm", out_imm32, e32);
    check("m32 out_illegal", out_ill32, i32);
    check("m32 out_tag", out_tag32, et);
    check("m32 illegal_cnt", cnt32, cnt32_m);
    check("m64 out_valid", out_valid64, v);
    check("m64 in_ready", in_ready64, mq.size() != DEPTH);
    check("m64 out_imm", out_imm64, e64);
    check("m64 out_illegal", out_ill64, i64);
    check("m64 out_tag", out_tag64, et);
    check("m64 illegal_cnt", cnt64, cnt64_m);
  end

  task automatic push(input logic [31:0] i, input logic [2:0] s,
                      input logic [4:0] t);
    instr = i; immsrc = s; in_tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  int   got[$];
  bit   accept;
  bit   pin_ill;

  initial begin
    // Pin the model with hand-computed values.
    check("pin I64", ref_imm(32'hFFF00093, 3'd0, 1'b1, pin_ill), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin B32", ref_imm(32'hFE000EE3, 3'd2, 1'b0, pin_ill), 64'hFFFF_FFFC);
    check("pin S32", ref_imm(32'hFE112E23, 3'd1, 1'b0, pin_ill), 64'hFFFF_FFFC);
    check("pin U64", ref_imm(32'h800000B7, 3'd4, 1'b1, pin_ill), 64'hFFFF_FFFF_8000_0000);
    check("pin SH64", ref_imm(32'h02001093, 3'd6, 1'b1, pin_ill), 64'h20);
    check("pin Z", ref_imm(32'h000F8000, 3'd5, 1'b0, pin_ill), 64'd31);

    // Reset state.
    #1;
    check("rst out_valid", out_valid32, 1'b0);
    check("rst in_ready", in_ready32, 1'b1);
    check("rst out_imm64", out_imm64, 64'h0);
    check("rst illegal_cnt", cnt32, 8'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single-entry latency and format vectors, consumer always ready.
    out_ready = 1'b1;
    push(32'hFFF00093, 3'd0, 5'd1);
    @(negedge clk);
    check("I valid", out_valid32, 1'b1);
    check("I imm32", out_imm32, 32'hFFFF_FFFF);
    check("I illegal", out_ill32, 1'b0);
    check("I imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    push(32'hFE000EE3, 3'd2, 5'd2);
    @(negedge clk);
    check("B imm32", out_imm32, 32'hFFFF_FFFC);
    push(32'h800000B7, 3'd4, 5'd3);
    @(negedge clk);
    check("U imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    check("U imm32", out_imm32, 32'h8000_0000);
    check("SH cnt32 before", cnt32, 8'd0);
    push(32'h02001093, 3'd6, 5'd4);
    @(negedge clk);
    check("SH imm64", out_imm64, 64'h20);
    check("SH ill64", out_ill64, 1'b0);
    check("SH imm32", out_imm32, 32'h0);
    check("SH ill32", out_ill32, 1'b1);
    check("SH cnt32 after", cnt32, 8'd1);
    push(32'h000F8000, 3'd5, 5'd5);
    @(negedge clk);
    check("Z imm32", out_imm32, 32'd31);
    push(32'hFE112E23, 3'd1, 5'd6);
    push(32'hFFDFF06F, 3'd3, 5'd7);
    push(32'h7FFFF037, 3'd4, 5'd8);
    push(32'h01F01093, 3'd6, 5'd9);
    repeat (2) @(posedge clk);

    // Backpressure: fill to DEPTH, hold the third, then drain in order.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; immsrc = 3'd0; instr = 32'h00100093; in_tag = 5'd1;
    @(posedge clk); #1 instr = 32'h80000093; in_tag = 5'd2;
    @(posedge clk); #1 instr = 32'h7FF00093; in_tag = 5'd3;
    @(negedge clk);
    check("full in_ready", in_ready32, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("held head tag", out_tag32, 5'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid32 && out_ready) got.push_back(int'(out_tag32));
      accept = in_valid && in_ready32;
      @(posedge clk); #1;
      if (accept) in_valid = 1'b0;
      @(negedge clk);
    end
    check("drain count", got.size(), 3);
    for (int k = 0; k < got.size() && k < 3; k++) check("drain order", got[k], k + 1);

    // Flush a full FIFO while presenting an illegal entry.
    out_ready = 1'b0;
    push(32'h00500093, 3'd0, 5'd10);
    push(32'h00600093, 3'd0, 5'd11);
    @(negedge clk);
    check("pre-flush full", in_ready32, 1'b0);
    flush = 1'b1; in_valid = 1'b1; immsrc = 3'd7; instr = '0; in_tag = 5'd12;
    out_ready = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("flush out_valid", out_valid32, 1'b0);
    check("flush in_ready", in_ready32, 1'b1);
    check("flush cnt32", cnt32, 8'd1);
    // Flush with room: the concurrent push is discarded too.
    push(32'h00700093, 3'd0, 5'd13);
    flush = 1'b1; in_valid = 1'b1; immsrc = 3'd7; in_tag = 5'd14;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush2 out_valid", out_valid32, 1'b0);
    check("flush2 cnt32", cnt32, 8'd1);
    check("flush2 cnt64", cnt64, 8'd0);
    repeat (3) @(posedge clk);

    // Saturation of the illegal-event counter.
    out_ready = 1'b1; instr = '0; immsrc = 3'd7; in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("sat cnt32", cnt32, 8'd255);
    check("sat cnt64", cnt64, 8'd255);
    repeat (2) @(posedge clk);

    // Reset with two entries queued: outputs clear without a clock edge.
    out_ready = 1'b0;
    push(32'h00100093, 3'd0, 5'd20);
    push(32'h00200093, 3'd0, 5'd21);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("async out_valid", out_valid32, 1'b0);
    check("async out_imm", out_imm32, 32'h0);
    check("async out_tag", out_tag64, 5'd0);
    check("async cnt", cnt32, 8'd0);
    check("async in_ready", in_ready64, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    out_ready = 1'b1;
    push(32'hFFF00093, 3'd0, 5'd22);
    @(negedge clk);
    check("post-rst valid", out_valid32, 1'b1);
    check("post-rst tag", out_tag32, 5'd22);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
